// File: rtl/plca_data_tx.sv
// PLCA data transmit path: MII pass-through when PLCA is off, otherwise a
// delay line that holds the MAC frame until a transmit opportunity is owned.
module plca_data_tx #(
    parameter int unsigned DL_DEPTH = 16
) (
    input  logic       TX_CLK,
    input  logic       plca_reset,
    input  logic       MAC_TX_EN,
    input  logic [3:0] MAC_TXD,
    input  logic       MAC_TX_ER,
    input  logic       plca_active,
    input  logic [1:0] tx_cmd,
    input  logic       committed,
    input  logic       PLS_CRS,
    input  logic       PLS_COL,
    output logic       PLS_TX_EN,
    output logic [3:0] PLS_TXD,
    output logic       PLS_TX_ER,
    output logic       MAC_CRS,
    output logic       MAC_COL,
    output logic       packetPending,
    output logic [2:0] plca_data_tx_state,
    output logic [4:0] dl_level
);

    typedef enum logic [2:0] {
        BYPASS   = 3'd0,
        IDLE     = 3'd1,
        PENDING  = 3'd2,
        TRANSMIT = 3'd3,
        COLLIDE  = 3'd4
    } state_t;

    localparam int unsigned AW    = $clog2(DL_DEPTH);
    localparam logic [4:0]  DEPTH = 5'(DL_DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DL_DEPTH - 1);

    state_t          state;
    logic            to_bypass;   // collision was caused by plca_active falling
    logic [4:0]      mem [DL_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [4:0]      count;
    logic            do_wr, do_rd, flush, fall, full, empty, overflow;

    // IDLE/PENDING symbol for the current control command: {TX_ER, TXD}
    function automatic logic [4:0] idle_sym(input logic [1:0] cmd);
        case (cmd)
            2'b00:   idle_sym = 5'b1_1000;
            2'b01:   idle_sym = 5'b1_0011;
            default: idle_sym = 5'b0_0000;
        endcase
    endfunction

    assign plca_data_tx_state = state;
    assign dl_level           = count;
    assign full               = (count == DEPTH);
    assign empty              = (count == 5'd0);
    assign fall               = !plca_active && (state != BYPASS);
    assign overflow           = (state == PENDING) && MAC_TX_EN && full;

    // Delay-line control derived from the current state and inputs
    always_comb begin
        do_wr = 1'b0;
        do_rd = 1'b0;
        flush = 1'b0;
        if (fall || state == BYPASS || state == COLLIDE) begin
            flush = 1'b1;
        end else begin
            case (state)
                IDLE:     do_wr = MAC_TX_EN;
                PENDING: begin
                    do_wr = MAC_TX_EN && !full;
                    flush = overflow;
                end
                TRANSMIT: begin
                    do_rd = !empty;
                    do_wr = MAC_TX_EN;
                end
                default:  flush = 1'b1;
            endcase
        end
    end

    // Delay-line storage; contents need no reset since pointers define validity
    always_ff @(posedge TX_CLK) begin
        if (do_wr) mem[wr_ptr] <= {MAC_TX_ER, MAC_TXD};
    end

    // Delay-line pointers and occupancy
    always_ff @(posedge TX_CLK) begin
        if (plca_reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + 5'(do_wr) - 5'(do_rd);
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge TX_CLK) begin
        if (plca_reset) begin
            state         <= BYPASS;
            to_bypass     <= 1'b0;
            PLS_TX_EN     <= 1'b0;
            PLS_TXD       <= '0;
            PLS_TX_ER     <= 1'b0;
            MAC_CRS       <= 1'b0;
            MAC_COL       <= 1'b0;
            packetPending <= 1'b0;
        end else if (fall) begin
            PLS_TX_EN     <= 1'b0;
            PLS_TXD       <= '0;
            PLS_TX_ER     <= 1'b0;
            packetPending <= 1'b0;
            if (MAC_TX_EN) begin
                state     <= COLLIDE;
                to_bypass <= 1'b1;
                MAC_CRS   <= 1'b1;
                MAC_COL   <= 1'b1;
            end else begin
                state     <= BYPASS;
                to_bypass <= 1'b0;
                MAC_CRS   <= PLS_CRS;
                MAC_COL   <= PLS_COL;
            end
        end else begin
            case (state)
                BYPASS: begin
                    PLS_TX_EN     <= MAC_TX_EN;
                    PLS_TXD       <= MAC_TXD;
                    PLS_TX_ER     <= MAC_TX_ER;
                    MAC_CRS       <= PLS_CRS;
                    MAC_COL       <= PLS_COL;
                    packetPending <= 1'b0;
                    if (plca_active && !MAC_TX_EN) state <= IDLE;
                end
                IDLE: begin
                    PLS_TX_EN              <= 1'b0;
                    {PLS_TX_ER, PLS_TXD}   <= idle_sym(tx_cmd);
                    MAC_CRS                <= 1'b0;
                    MAC_COL                <= 1'b0;
                    packetPending          <= 1'b0;
                    if (MAC_TX_EN) begin
                        if (committed) begin
                            state <= TRANSMIT;
                        end else begin
                            state         <= PENDING;
                            packetPending <= 1'b1;
                        end
                    end
                end
                PENDING: begin
                    PLS_TX_EN            <= 1'b0;
                    {PLS_TX_ER, PLS_TXD} <= idle_sym(tx_cmd);
                    MAC_CRS              <= 1'b1;
                    MAC_COL              <= 1'b0;
                    if (overflow) begin
                        state         <= COLLIDE;
                        packetPending <= 1'b0;
                        MAC_COL       <= 1'b1;
                    end else if (committed) begin
                        state         <= TRANSMIT;
                        packetPending <= 1'b0;
                    end
                end
                TRANSMIT: begin
                    MAC_CRS       <= 1'b1;
                    MAC_COL       <= PLS_COL;
                    packetPending <= 1'b0;
                    if (!empty) begin
                        PLS_TX_EN            <= 1'b1;
                        {PLS_TX_ER, PLS_TXD} <= mem[rd_ptr];
                    end else begin
                        PLS_TX_EN <= 1'b0;
                        PLS_TXD   <= '0;
                        PLS_TX_ER <= 1'b0;
                        if (!MAC_TX_EN) state <= IDLE;
                    end
                end
                COLLIDE: begin
                    PLS_TX_EN     <= 1'b0;
                    PLS_TXD       <= '0;
                    PLS_TX_ER     <= 1'b0;
                    packetPending <= 1'b0;
                    if (MAC_TX_EN) begin
                        MAC_COL <= 1'b1;
                        MAC_CRS <= 1'b1;
                    end else begin
                        MAC_COL   <= 1'b0;
                        MAC_CRS   <= 1'b0;
                        state     <= to_bypass ? BYPASS : IDLE;
                        to_bypass <= 1'b0;
                    end
                end
                default: state <= BYPASS;
            endcase
        end
    end

endmodule

// File: tb/tb_plca_data_tx.sv
// Scoreboard bench for plca_data_tx: expected PHY nibbles are queued as the
// MAC sends them and popped by a monitor whenever PLS_TX_EN is high.
module tb_plca_data_tx;

    logic       TX_CLK = 1'b0;
    logic       plca_reset, MAC_TX_EN, MAC_TX_ER, plca_active, committed;
    logic       PLS_CRS, PLS_COL;
    logic [3:0] MAC_TXD;
    logic [1:0] tx_cmd;
    logic       PLS_TX_EN, PLS_TX_ER, MAC_CRS, MAC_COL, packetPending;
    logic [3:0] PLS_TXD;
    logic [2:0] plca_data_tx_state;
    logic [4:0] dl_level;

    logic [4:0] exp_q [$];
    int vectors     = 0;
    int miscompares = 0;
    int n_tx;

    plca_data_tx #(.DL_DEPTH(16)) dut (
        .TX_CLK(TX_CLK), .plca_reset(plca_reset),
        .MAC_TX_EN(MAC_TX_EN), .MAC_TXD(MAC_TXD), .MAC_TX_ER(MAC_TX_ER),
        .plca_active(plca_active), .tx_cmd(tx_cmd), .committed(committed),
        .PLS_CRS(PLS_CRS), .PLS_COL(PLS_COL),
        .PLS_TX_EN(PLS_TX_EN), .PLS_TXD(PLS_TXD), .PLS_TX_ER(PLS_TX_ER),
        .MAC_CRS(MAC_CRS), .MAC_COL(MAC_COL), .packetPending(packetPending),
        .plca_data_tx_state(plca_data_tx_state), .dl_level(dl_level)
    );

    always #5 TX_CLK = ~TX_CLK;

    // Monitor: every transmitted nibble must match the next queued one
    always @(negedge TX_CLK) begin
        logic [4:0] e;
        if (PLS_TX_EN === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL tx_unexpected: got %02h expected no transmit", {PLS_TX_ER, PLS_TXD});
            end else begin
                e = exp_q.pop_front();
                if ({PLS_TX_ER, PLS_TXD} !== e) begin
                    miscompares++;
                    $display("FAIL tx_data: got %02h expected %02h", {PLS_TX_ER, PLS_TXD}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge TX_CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] nib, input logic er, input bit push);
        MAC_TX_EN = 1'b1;
        MAC_TXD   = nib;
        MAC_TX_ER = er;
        if (push) exp_q.push_back({er, nib});
        tick();
    endtask

    task automatic mac_off();
        MAC_TX_EN = 1'b0;
        MAC_TXD   = 4'h0;
        MAC_TX_ER = 1'b0;
    endtask

    initial begin
        plca_reset = 1'b1; plca_active = 1'b0; committed = 1'b0;
        tx_cmd = 2'b10; PLS_CRS = 1'b0; PLS_COL = 1'b0;
        mac_off();
        tick(); tick();
        chk("rst_state", plca_data_tx_state, 0);
        chk("rst_level", dl_level, 0);
        chk("rst_outs", {PLS_TX_EN, PLS_TXD, PLS_TX_ER, MAC_CRS, MAC_COL, packetPending}, 0);

        // Bypass: nibbles 1..8 forwarded one cycle later
        plca_reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            PLS_CRS = (i == 4);
            PLS_COL = (i == 5);
            send(4'(i), 1'b0, 1'b1);
            chk("byp_txen", PLS_TX_EN, 1);
            chk("byp_crs", MAC_CRS, (i == 4) ? 1 : 0);
            chk("byp_col", MAC_COL, (i == 5) ? 1 : 0);
        end
        PLS_CRS = 1'b0; PLS_COL = 1'b0;
        mac_off(); tick();
        chk("byp_end_txen", PLS_TX_EN, 0);
        chk("byp_pending", packetPending, 0);

        // Enter IDLE, then idle symbols per command
        plca_active = 1'b1; tick();
        chk("idle_state", plca_data_tx_state, 1);
        tx_cmd = 2'b01; tick();
        chk("commit_sym", {PLS_TX_EN, PLS_TX_ER, PLS_TXD}, 5'b0_1_0011);
        tx_cmd = 2'b00; tick();
        chk("beacon_sym", {PLS_TX_EN, PLS_TX_ER, PLS_TXD}, 5'b0_1_1000);
        tx_cmd = 2'b11; tick();
        chk("cmd11_sym", {PLS_TX_EN, PLS_TX_ER, PLS_TXD}, 0);
        tx_cmd = 2'b10;

        // Pending frame of 10 nibbles, commit granted later
        for (int i = 0; i < 10; i++) begin
            send(4'(i + 3), (i == 5), 1'b1);
            chk("pend_pp", packetPending, 1);
            chk("pend_state", plca_data_tx_state, 2);
            if (i > 0) chk("pend_crs", MAC_CRS, 1);
        end
        chk("pend_level", dl_level, 10);
        mac_off(); tick(); tick();
        chk("pend_hold_pp", packetPending, 1);
        chk("pend_hold_txen", PLS_TX_EN, 0);
        committed = 1'b1; tick();
        chk("commit_pp", packetPending, 0);
        chk("commit_state", plca_data_tx_state, 3);
        committed = 1'b0;
        n_tx = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (PLS_TX_EN) n_tx++;
        end
        chk("drain_count", n_tx, 10);
        chk("drain_state", plca_data_tx_state, 1);
        chk("drain_level", dl_level, 0);

        // Overflow: 40-nibble frame, never committed
        for (int i = 1; i <= 40; i++) begin
            send(4'(i), 1'b0, 1'b0);
            chk("ovf_state", plca_data_tx_state, (i < 17) ? 2 : 4);
            chk("ovf_col", MAC_COL, (i < 17) ? 0 : 1);
        end
        chk("ovf_pp", packetPending, 0);
        chk("ovf_level", dl_level, 0);
        mac_off(); tick();
        chk("ovf_exit_state", plca_data_tx_state, 1);
        chk("ovf_exit_col", MAC_COL, 0);

        // plca_active drop during TRANSMIT with 5 nibbles buffered
        for (int i = 0; i < 4; i++) send(4'(i + 1), 1'b0, 1'b0);
        committed = 1'b1;
        send(4'h5, 1'b0, 1'b0);
        exp_q.push_back(5'h01);
        send(4'h6, 1'b0, 1'b0);
        chk("drop_pre_txen", PLS_TX_EN, 1);
        chk("drop_pre_level", dl_level, 5);
        committed = 1'b0; plca_active = 1'b0;
        send(4'h7, 1'b0, 1'b0);
        chk("drop_txen", PLS_TX_EN, 0);
        chk("drop_col", MAC_COL, 1);
        chk("drop_state", plca_data_tx_state, 4);
        chk("drop_level", dl_level, 0);
        send(4'h8, 1'b0, 1'b0);
        chk("drop_col_hold", MAC_COL, 1);
        mac_off(); tick();
        chk("drop_bypass", plca_data_tx_state, 0);

        // Burst: committed frames go straight to TRANSMIT
        plca_active = 1'b1; tick();
        chk("burst_idle", plca_data_tx_state, 1);
        committed = 1'b1;
        send(4'hA, 1'b0, 1'b1);
        chk("burst1_state", plca_data_tx_state, 3);
        chk("burst1_pp", packetPending, 0);
        send(4'hB, 1'b0, 1'b1);
        send(4'hC, 1'b1, 1'b1);
        mac_off();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("burst1_pp_hold", packetPending, 0);
        end
        chk("burst1_end", plca_data_tx_state, 1);
        send(4'hD, 1'b0, 1'b1);
        chk("burst2_state", plca_data_tx_state, 3);
        send(4'hE, 1'b0, 1'b1);
        chk("burst2_pp", packetPending, 0);
        mac_off(); tick(); tick(); tick();
        chk("burst2_end", plca_data_tx_state, 1);

        // Reset mid-frame discards the delay line
        send(4'h9, 1'b0, 1'b1);
        send(4'h2, 1'b0, 1'b0);
        chk("rstmid_pre_txen", PLS_TX_EN, 1);
        plca_reset = 1'b1;
        send(4'h3, 1'b0, 1'b0);
        chk("rstmid_txen", PLS_TX_EN, 0);
        chk("rstmid_state", plca_data_tx_state, 0);
        chk("rstmid_level", dl_level, 0);
        chk("rstmid_outs", {MAC_CRS, MAC_COL, packetPending, PLS_TXD, PLS_TX_ER}, 0);
        plca_reset = 1'b0; committed = 1'b0;
        mac_off(); tick();
        chk("rstmid_after_txen", PLS_TX_EN, 0);
        chk("rstmid_after_state", plca_data_tx_state, 1);
        tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
